// File: rtl/spike_packetizer.sv
// Spike event packetizer: stamps each event with its delivery slot, buffers it in a FIFO and
// presents it to the router through a registered output slot, dropping entries that go stale.
module spike_packetizer #(
    parameter int unsigned N_COUNT     = 256,
    parameter int unsigned GRANULARITY = 4,
    parameter int unsigned PKT_SIZE    = 32,
    parameter int unsigned DEPTH       = 8,
    localparam int unsigned AW         = $clog2(N_COUNT),
    localparam int unsigned TW         = $clog2(GRANULARITY)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                spike_valid,
    output logic                spike_ready,
    input  logic [AW-1:0]       spike_axon,
    input  logic [TW-1:0]       spike_delay,
    input  logic [7:0]          spike_cycles,
    output logic [PKT_SIZE-1:0] pkt_out,
    output logic                pkt_valid,
    input  logic                pkt_ready,
    output logic [15:0]         late_drops,
    output logic [TW-1:0]       tick_ptr
);
    localparam int unsigned TW_D = $clog2(DEPTH);

    logic [PKT_SIZE-1:0] mem_pkt    [DEPTH];
    logic [TW-1:0]       mem_remain [DEPTH];
    logic                mem_exp    [DEPTH];
    logic [TW_D:0]       wptr, rptr;

    logic [PKT_SIZE-1:0] out_pkt_q, out_pkt_d;
    logic [TW-1:0]       out_remain_q, out_remain_d;
    logic                out_valid_q, out_valid_d;
    logic                exp_out;

    logic                empty, full, head_exp, handover, drop_head, load, pop, push;
    logic [TW-1:0]       slot;
    logic [PKT_SIZE-1:0] new_pkt;
    logic [16:0]         drop_sum;
    logic [TW_D-1:0]     ridx, widx;

    assign ridx  = rptr[TW_D-1:0];
    assign widx  = wptr[TW_D-1:0];
    assign empty = (wptr == rptr);
    assign full  = (wptr[TW_D] != rptr[TW_D]) && (widx == ridx);

    assign head_exp  = !empty && mem_exp[ridx];
    assign handover  = out_valid_q && pkt_ready;
    assign drop_head = head_exp;
    assign load      = !empty && !head_exp && (!out_valid_q || handover);
    assign pop       = drop_head || load;
    // A pop in the same cycle frees the slot the push will land in.
    assign spike_ready = !full || pop;
    assign push        = spike_valid && spike_ready;

    assign slot    = tick_ptr + spike_delay;
    assign new_pkt = (PKT_SIZE'(slot) << (PKT_SIZE - GRANULARITY))
                   | (PKT_SIZE'(spike_axon) << 8)
                   | PKT_SIZE'(spike_cycles);

    always_comb begin
        out_valid_d  = out_valid_q && !handover;
        out_pkt_d    = out_pkt_q;
        out_remain_d = out_remain_q;
        exp_out      = 1'b0;
        if (load) begin
            out_valid_d  = 1'b1;
            out_pkt_d    = mem_pkt[ridx];
            out_remain_d = mem_remain[ridx];
        end
        // A packet handed over this cycle is already gone and never counts as late.
        if (tick && out_valid_d) begin
            if (out_remain_d == '0) begin
                out_valid_d = 1'b0;
                exp_out     = 1'b1;
            end else begin
                out_remain_d = out_remain_d - TW'(1);
            end
        end
    end

    assign drop_sum = {1'b0, late_drops} + 17'(drop_head) + 17'(exp_out);

    always_ff @(posedge clk) begin
        if (push) mem_pkt[widx] <= new_pkt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_remain[i] <= '0;
                mem_exp[i]    <= 1'b0;
            end
        end else begin
            if (tick) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (mem_remain[i] == '0) mem_exp[i] <= 1'b1;
                    else                     mem_remain[i] <= mem_remain[i] - TW'(1);
                end
            end
            if (push) begin
                mem_remain[widx] <= spike_delay;
                mem_exp[widx]    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            out_valid_q  <= 1'b0;
            out_pkt_q    <= '0;
            out_remain_q <= '0;
            late_drops   <= '0;
            tick_ptr     <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            out_valid_q  <= out_valid_d;
            out_pkt_q    <= out_pkt_d;
            out_remain_q <= out_remain_d;
            late_drops   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            tick_ptr     <= tick_ptr + TW'(tick);
        end
    end

    assign pkt_out   = out_pkt_q;
    assign pkt_valid = out_valid_q;

endmodule

// File: tb/tb_spike_packetizer.sv
// Randomised bench for spike_packetizer with a queue-based reference model and directed
// scenarios pinning the model to hand-computed values.
module tb_spike_packetizer;
    localparam int G     = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        spike_valid = 1'b0;
    logic        spike_ready;
    logic [7:0]  spike_axon = '0;
    logic [1:0]  spike_delay = '0;
    logic [7:0]  spike_cycles = '0;
    logic [31:0] pkt_out;
    logic        pkt_valid;
    logic        pkt_ready = 1'b0;
    logic [15:0] late_drops;
    logic [1:0]  tick_ptr;

    spike_packetizer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .spike_valid  (spike_valid),
        .spike_ready  (spike_ready),
        .spike_axon   (spike_axon),
        .spike_delay  (spike_delay),
        .spike_cycles (spike_cycles),
        .pkt_out      (pkt_out),
        .pkt_valid    (pkt_valid),
        .pkt_ready    (pkt_ready),
        .late_drops   (late_drops),
        .tick_ptr     (tick_ptr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pkt;
        int          rem;
        bit          exp;
    } ent_t;

    ent_t        q[$];
    bit          m_ov;
    logic [31:0] m_opkt;
    int          m_orem;
    int          m_drops;
    int          m_tptr;

    int          checks = 0;
    int          failures = 0;
    int          n_acc = 0;
    logic [31:0] delivered[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int slot, input int axon, input int cyc);
        return (32'(slot) << 28) | (32'(axon) << 8) | 32'(cyc);
    endfunction

    task automatic model_reset();
        q.delete();
        m_ov = 0; m_opkt = '0; m_orem = 0; m_drops = 0; m_tptr = 0;
    endtask

    task automatic compare_outputs();
        chk("pkt_valid", 32'(pkt_valid), 32'(m_ov));
        if (m_ov) chk("pkt_out", pkt_out, m_opkt);
        chk("late_drops", 32'(late_drops), 32'(m_drops));
        chk("tick_ptr", 32'(tick_ptr), 32'(m_tptr));
    endtask

    // One clock cycle: drive inputs, check ready, advance the model, check outputs after the edge.
    task automatic step(input bit v, input int ax, input int dl, input int cy,
                        input bit rdy, input bit tk);
        bit   hand, drp, ld, erdy, acc;
        int   inc;
        ent_t e;
        spike_valid = v; spike_axon = 8'(ax); spike_delay = 2'(dl);
        spike_cycles = 8'(cy); pkt_ready = rdy; tick = tk;
        #1;
        hand = m_ov && rdy;
        drp  = (q.size() > 0) && q[0].exp;
        ld   = (q.size() > 0) && !q[0].exp && (!m_ov || hand);
        erdy = (q.size() < DEPTH) || drp || ld;
        acc  = v && erdy;
        chk("spike_ready", 32'(spike_ready), 32'(erdy));
        if (v && spike_ready) n_acc++;
        if (pkt_valid && rdy) delivered.push_back(pkt_out);
        inc = 0;
        if (hand) m_ov = 0;
        if (drp) begin
            void'(q.pop_front());
            inc++;
        end
        if (ld) begin
            e = q.pop_front();
            m_ov = 1; m_opkt = e.pkt; m_orem = e.rem;
        end
        if (tk) begin
            foreach (q[i]) begin
                if (q[i].rem == 0) q[i].exp = 1;
                else q[i].rem = q[i].rem - 1;
            end
            if (m_ov) begin
                if (m_orem == 0) begin
                    m_ov = 0;
                    inc++;
                end else m_orem--;
            end
        end
        if (acc) begin
            e.pkt = mk((m_tptr + dl) % G, ax, cy);
            e.rem = dl;
            e.exp = 0;
            q.push_back(e);
        end
        m_drops = (m_drops + inc > 65535) ? 65535 : m_drops + inc;
        if (tk) m_tptr = (m_tptr + 1) % G;
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic idle(input bit rdy, input bit tk);
        step(0, 0, 0, 0, rdy, tk);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("reset pkt_valid", 32'(pkt_valid), 32'd0);
        chk("reset late_drops", 32'(late_drops), 32'd0);
        chk("reset tick_ptr", 32'(tick_ptr), 32'd0);
        chk("reset spike_ready", 32'(spike_ready), 32'd1);

        // Single event, two-cycle latency.
        step(1, 5, 2, 10, 1, 0);
        chk("single latency1", 32'(pkt_valid), 32'd0);
        idle(1, 0);
        chk("single valid", 32'(pkt_valid), 32'd1);
        chk("single pkt", pkt_out, 32'h2000_050A);
        idle(1, 0);

        // Slot wraps modulo GRANULARITY.
        repeat (3) idle(1, 1);
        chk("wrap tick_ptr", 32'(tick_ptr), 32'd3);
        step(1, 1, 2, 0, 1, 0);
        idle(1, 0);
        chk("wrap slot", 32'(pkt_out[31:28]), 32'h1);
        idle(1, 0);

        // Backpressure fills buffer plus output slot.
        n_acc = 0;
        for (int i = 0; i < 10; i++) step(1, i, 3, i, 0, 0);
        chk("full accepted", 32'(n_acc), 32'd9);
        chk("full ready", 32'(spike_ready), 32'd0);
        delivered.delete();
        repeat (12) idle(1, 0);
        chk("full delivered", 32'(delivered.size()), 32'd9);
        for (int i = 0; i < 9 && i < delivered.size(); i++)
            chk("full order", 32'(delivered[i][15:8]), 32'(i));

        // Expiry of the presented packet; the entry behind it survives.
        step(1, 20, 0, 1, 0, 0);
        step(1, 21, 1, 2, 0, 0);
        idle(0, 0);
        idle(0, 1);
        chk("expiry valid", 32'(pkt_valid), 32'd0);
        chk("expiry drops", 32'(late_drops), 32'd1);
        idle(1, 0);
        chk("survivor valid", 32'(pkt_valid), 32'd1);
        chk("survivor axon", 32'(pkt_out[15:8]), 32'd21);
        idle(1, 0);

        // Tick coincident with accept uses the pre-increment pointer.
        idle(1, 1);
        chk("coinc pre ptr", 32'(tick_ptr), 32'd1);
        step(1, 7, 1, 3, 1, 1);
        chk("coinc ptr", 32'(tick_ptr), 32'd2);
        idle(1, 0);
        chk("coinc slot", 32'(pkt_out[31:28]), 32'h2);
        idle(1, 0);

        // Reset mid-stream.
        for (int i = 0; i < 4; i++) step(1, 40 + i, 3, i, 0, 0);
        spike_valid = 0; tick = 0;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst valid", 32'(pkt_valid), 32'd0);
        chk("midrst ptr", 32'(tick_ptr), 32'd0);
        chk("midrst drops", 32'(late_drops), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1, 9, 1, 8'h33, 1, 0);
        idle(1, 0);
        chk("post rst pkt", pkt_out, 32'h1000_0933);
        idle(1, 0);

        // Randomised traffic with varying backpressure and tick density.
        for (int phase = 0; phase < 6; phase++) begin
            int rdy_pct = 20 + phase * 15;
            int tk_pct = (phase % 2) ? 30 : 8;
            for (int c = 0; c < 500; c++)
                step($urandom_range(0, 99) < 60, $urandom_range(0, 255), $urandom_range(0, 3),
                     $urandom_range(0, 255), $urandom_range(0, 99) < rdy_pct,
                     $urandom_range(0, 99) < tk_pct);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
